// File: rtl/axis_s.sv
// AXI-Stream slave receiver: FWFT FIFO buffering {tlast, tdata} beats for a local
// consumer, plus packet boundary tracking (last packet length and packet count).
module axis_s #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              tvalid,
  input  logic              tlast,
  input  logic [DATA_W-1:0] tdata,
  output logic              tready,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [AW:0]       level,
  output logic              pkt_done,
  output logic [15:0]       pkt_len,
  output logic [15:0]       pkt_cnt
);

  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             wr_entry;

  logic [AW-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0]      level_q,    level_d;
  logic [CNT_W-1:0]   cur_len_q,  cur_len_d;
  logic [CNT_W-1:0]   pkt_len_q,  pkt_len_d;
  logic [CNT_W-1:0]   pkt_cnt_q,  pkt_cnt_d;
  logic               pkt_done_q, pkt_done_d;

  logic               wr_fire;
  logic               rd_fire;
  logic [CNT_W-1:0]   len_inc;

  // Handshake status comes only from registered level, never from tvalid/rd_en.
  assign tready   = (level_q != LW'(DEPTH));
  assign rd_valid = (level_q != LW'(0));
  assign wr_fire  = tvalid & tready;
  assign rd_fire  = rd_en & rd_valid;

  assign wr_entry = '{last: tlast, data: tdata};
  assign rd_data  = mem_q[rd_ptr_q].data;
  assign rd_last  = mem_q[rd_ptr_q].last;

  assign level    = level_q;
  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;
  assign pkt_cnt  = pkt_cnt_q;

  // Saturating increment of the in-flight packet beat count.
  assign len_inc = (cur_len_q == {CNT_W{1'b1}}) ? cur_len_q : cur_len_q + CNT_W'(1);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cur_len_d  = cur_len_q;
    pkt_len_d  = pkt_len_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_done_d = 1'b0;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (wr_fire) begin
      if (tlast) begin
        pkt_len_d  = len_inc;
        cur_len_d  = '0;
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
        pkt_done_d = 1'b1;
      end else begin
        cur_len_d  = len_inc;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cur_len_q  <= '0;
      pkt_len_q  <= '0;
      pkt_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cur_len_q  <= cur_len_d;
      pkt_len_q  <= pkt_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Storage is not reset; contents are only observable while rd_valid is high.
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
